// File: rtl/decode_queue.sv
// Multi-lane decode stage: per-lane decoders feed a circular queue of decoded
// entries; the oldest entries are presented in order to rename/dispatch.

package decode_queue_pkg;

  typedef enum logic [5:0] {
    OP_INVALID,
    OP_SLL, OP_SRL, OP_SRA, OP_SLLV, OP_SRLV, OP_SRAV,
    OP_ADD, OP_ADDU, OP_SUB, OP_SUBU, OP_AND, OP_OR, OP_XOR, OP_NOR,
    OP_SLT, OP_SLTU, OP_LUI,
    OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MFHI, OP_MFLO, OP_MTHI, OP_MTLO,
    OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_SB, OP_SH, OP_SW,
    OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_BLTZ, OP_BGEZ,
    OP_J, OP_JAL, OP_JR, OP_JALR,
    OP_SYSCALL, OP_BREAK
  } op_t;

  typedef enum logic [2:0] {
    FU_INVALID, FU_ALU, FU_MUL, FU_LSU, FU_BRANCH, FU_SYS
  } fu_t;

  typedef enum logic [1:0] {
    ControlFlow_None, ControlFlow_Branch, ControlFlow_Jump, ControlFlow_JumpReg
  } cf_t;

  typedef struct packed {
    op_t         op;
    fu_t         fu;
    cf_t         cf;
    logic        is_controlflow;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        use_imm;
  } decoded_instr_t;

endpackage

module decoder
  import decode_queue_pkg::*;
(
  input  logic [31:0]    instr,
  output decoded_instr_t decoded
);

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rt;
  logic [31:0] simm;
  logic [31:0] zimm;

  assign opcode = instr[31:26];
  assign funct  = instr[5:0];
  assign rt     = instr[20:16];
  assign simm   = {{16{instr[15]}}, instr[15:0]};
  assign zimm   = {16'b0, instr[15:0]};

  op_t         op;
  fu_t         fu;
  cf_t         cf;
  logic [4:0]  rd;
  logic [31:0] imm;
  logic        use_imm;
  logic        i_dest;

  always_comb begin
    op      = OP_INVALID;
    rd      = '0;
    imm     = simm;
    use_imm = 1'b0;
    i_dest  = 1'b0;
    case (opcode)
      6'h00: begin
        rd = instr[15:11];
        case (funct)
          6'h00: op = OP_SLL;
          6'h02: op = OP_SRL;
          6'h03: op = OP_SRA;
          6'h04: op = OP_SLLV;
          6'h06: op = OP_SRLV;
          6'h07: op = OP_SRAV;
          6'h08: op = OP_JR;
          6'h09: op = OP_JALR;
          6'h0c: op = OP_SYSCALL;
          6'h0d: op = OP_BREAK;
          6'h10: op = OP_MFHI;
          6'h11: op = OP_MTHI;
          6'h12: op = OP_MFLO;
          6'h13: op = OP_MTLO;
          6'h18: op = OP_MULT;
          6'h19: op = OP_MULTU;
          6'h1a: op = OP_DIV;
          6'h1b: op = OP_DIVU;
          6'h20: op = OP_ADD;
          6'h21: op = OP_ADDU;
          6'h22: op = OP_SUB;
          6'h23: op = OP_SUBU;
          6'h24: op = OP_AND;
          6'h25: op = OP_OR;
          6'h26: op = OP_XOR;
          6'h27: op = OP_NOR;
          6'h2a: op = OP_SLT;
          6'h2b: op = OP_SLTU;
          default: op = OP_INVALID;
        endcase
        // constant shifts carry shamt as their immediate operand
        if (op inside {OP_SLL, OP_SRL, OP_SRA}) begin
          imm     = {27'b0, instr[10:6]};
          use_imm = 1'b1;
        end
        if (op inside {OP_JR, OP_SYSCALL, OP_BREAK, OP_MTHI, OP_MTLO, OP_MULT,
                       OP_MULTU, OP_DIV, OP_DIVU, OP_INVALID})
          rd = '0;
      end
      6'h01: begin
        case (rt)
          5'h00:   op = OP_BLTZ;
          5'h01:   op = OP_BGEZ;
          default: op = OP_INVALID;
        endcase
      end
      6'h02: begin op = OP_J;   imm = {6'b0, instr[25:0]}; end
      6'h03: begin op = OP_JAL; imm = {6'b0, instr[25:0]}; rd = 5'd31; end
      6'h04: op = OP_BEQ;
      6'h05: op = OP_BNE;
      6'h06: op = OP_BLEZ;
      6'h07: op = OP_BGTZ;
      6'h08: begin op = OP_ADD;  i_dest = 1'b1; end
      6'h09: begin op = OP_ADDU; i_dest = 1'b1; end
      6'h0a: begin op = OP_SLT;  i_dest = 1'b1; end
      6'h0b: begin op = OP_SLTU; i_dest = 1'b1; end
      6'h0c: begin op = OP_AND;  i_dest = 1'b1; imm = zimm; end
      6'h0d: begin op = OP_OR;   i_dest = 1'b1; imm = zimm; end
      6'h0e: begin op = OP_XOR;  i_dest = 1'b1; imm = zimm; end
      6'h0f: begin op = OP_LUI;  i_dest = 1'b1; imm = {instr[15:0], 16'b0}; end
      6'h20: begin op = OP_LB;   i_dest = 1'b1; end
      6'h21: begin op = OP_LH;   i_dest = 1'b1; end
      6'h23: begin op = OP_LW;   i_dest = 1'b1; end
      6'h24: begin op = OP_LBU;  i_dest = 1'b1; end
      6'h25: begin op = OP_LHU;  i_dest = 1'b1; end
      6'h28: begin op = OP_SB;   use_imm = 1'b1; end
      6'h29: begin op = OP_SH;   use_imm = 1'b1; end
      6'h2b: begin op = OP_SW;   use_imm = 1'b1; end
      default: op = OP_INVALID;
    endcase
    if (i_dest) begin
      rd      = rt;
      use_imm = 1'b1;
    end
  end

  always_comb begin
    fu = FU_INVALID;
    cf = ControlFlow_None;
    case (op)
      OP_SLL, OP_SRL, OP_SRA, OP_SLLV, OP_SRLV, OP_SRAV, OP_ADD, OP_ADDU,
      OP_SUB, OP_SUBU, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLT, OP_SLTU,
      OP_LUI:
        fu = FU_ALU;
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MFHI, OP_MFLO, OP_MTHI, OP_MTLO:
        fu = FU_MUL;
      OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_SB, OP_SH, OP_SW:
        fu = FU_LSU;
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_BLTZ, OP_BGEZ: begin
        fu = FU_BRANCH;
        cf = ControlFlow_Branch;
      end
      OP_J, OP_JAL: begin
        fu = FU_BRANCH;
        cf = ControlFlow_Jump;
      end
      OP_JR, OP_JALR: begin
        fu = FU_BRANCH;
        cf = ControlFlow_JumpReg;
      end
      OP_SYSCALL, OP_BREAK:
        fu = FU_SYS;
      default: fu = FU_INVALID;
    endcase
  end

  always_comb begin
    decoded                = '0;
    decoded.op             = op;
    decoded.fu             = fu;
    decoded.cf             = cf;
    decoded.is_controlflow = (cf != ControlFlow_None);
    decoded.rs             = instr[25:21];
    decoded.rt             = rt;
    decoded.rd             = rd;
    decoded.imm            = imm;
    decoded.use_imm        = use_imm;
  end

endmodule

module decode_queue
  import decode_queue_pkg::*;
#(
  parameter int FETCH_WIDTH = 2,
  parameter int ISSUE_WIDTH = 2,
  parameter int DEPTH       = 8
) (
  input  logic                                            clk,
  input  logic                                            rst,
  input  logic                                            flush,
  input  logic [FETCH_WIDTH-1:0]                          fetch_valid,
  input  logic [FETCH_WIDTH-1:0][31:0]                    fetch_instr,
  input  logic [FETCH_WIDTH-1:0][31:0]                    fetch_pc,
  output logic                                            fetch_ready,
  output logic [ISSUE_WIDTH-1:0]                          issue_valid,
  output logic [ISSUE_WIDTH-1:0][$bits(decoded_instr_t)-1:0] issue_decoded,
  output logic [ISSUE_WIDTH-1:0][31:0]                    issue_pc,
  output logic [ISSUE_WIDTH-1:0][31:0]                    issue_instr,
  output logic [ISSUE_WIDTH-1:0]                          issue_ex_ri,
  output logic [ISSUE_WIDTH-1:0]                          issue_delayslot,
  input  logic [$clog2(ISSUE_WIDTH+1)-1:0]                issue_num,
  output logic [$clog2(DEPTH+1)-1:0]                      count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int FN_W  = $clog2(FETCH_WIDTH+1);

  typedef struct packed {
    decoded_instr_t dec;
    logic [31:0]    pc;
    logic [31:0]    instr;
    logic           ex_ri;
    logic           delayslot;
  } entry_t;

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic             last_cf;
  entry_t           mem [DEPTH];

  decoded_instr_t   dec      [FETCH_WIDTH];
  entry_t           lane_e   [FETCH_WIDTH];
  logic             lane_ds  [FETCH_WIDTH];
  logic [FN_W-1:0]  valid_n;
  logic [FN_W-1:0]  push_n;
  logic             push;
  logic             last_cf_next;

  for (genvar g = 0; g < FETCH_WIDTH; g++) begin : g_lane
    decoder u_dec (
      .instr   (fetch_instr[g]),
      .decoded (dec[g])
    );
    // a control-flow op in lane g-1 puts lane g in its delay slot
    if (g == 0) begin : g_first
      assign lane_ds[g] = last_cf;
    end else begin : g_rest
      assign lane_ds[g] = dec[g-1].is_controlflow;
    end
    assign lane_e[g] = '{dec:       dec[g],
                         pc:        fetch_pc[g],
                         instr:     fetch_instr[g],
                         ex_ri:     (dec[g].op == OP_INVALID),
                         delayslot: lane_ds[g]};
  end

  assign fetch_ready = (count <= CNT_W'(DEPTH - FETCH_WIDTH));
  assign push        = fetch_ready & ~flush;

  // fetch_valid is contiguous from lane 0, so the last valid lane is push_n-1
  always_comb begin
    valid_n      = '0;
    last_cf_next = last_cf;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      if (fetch_valid[i]) begin
        valid_n      = valid_n + FN_W'(1);
        last_cf_next = dec[i].is_controlflow;
      end
    end
    push_n = push ? valid_n : '0;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      for (int i = 0; i < FETCH_WIDTH; i++) begin
        if (fetch_valid[i]) mem[tail + PTR_W'(i)] <= lane_e[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      last_cf <= 1'b0;
    end else begin
      head  <= head + PTR_W'(issue_num);
      tail  <= tail + PTR_W'(push_n);
      count <= count + CNT_W'(push_n) - CNT_W'(issue_num);
      if (push_n != '0) last_cf <= last_cf_next;
    end
  end

  always_comb begin
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      issue_valid[i]     = (count > CNT_W'(i));
      issue_decoded[i]   = mem[head + PTR_W'(i)].dec;
      issue_pc[i]        = mem[head + PTR_W'(i)].pc;
      issue_instr[i]     = mem[head + PTR_W'(i)].instr;
      issue_ex_ri[i]     = mem[head + PTR_W'(i)].ex_ri;
      issue_delayslot[i] = mem[head + PTR_W'(i)].delayslot;
    end
  end

endmodule

// File: tb/tb_decode_queue.sv
// Directed bench for decode_queue: vector table for occupancy/flow control,
// hand sequences for decode fields, delay slots, flush, reset and wrap streaming.

module tb_decode_queue;
  import decode_queue_pkg::*;

  localparam int FW    = 2;
  localparam int IW    = 2;
  localparam int DEPTH = 8;
  localparam int DW    = $bits(decoded_instr_t);
  localparam logic [31:0] B = 32'hBFC00000;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 flush;
  logic [FW-1:0]        fetch_valid;
  logic [FW-1:0][31:0]  fetch_instr;
  logic [FW-1:0][31:0]  fetch_pc;
  logic                 fetch_ready;
  logic [IW-1:0]        issue_valid;
  logic [IW-1:0][DW-1:0] issue_decoded;
  logic [IW-1:0][31:0]  issue_pc;
  logic [IW-1:0][31:0]  issue_instr;
  logic [IW-1:0]        issue_ex_ri;
  logic [IW-1:0]        issue_delayslot;
  logic [1:0]           issue_num;
  logic [3:0]           count;

  int tests = 0;
  int fails = 0;
  logic [31:0] pc_ctr = 32'h0000_1000;

  decode_queue #(.FETCH_WIDTH(FW), .ISSUE_WIDTH(IW), .DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst             (rst),
    .flush           (flush),
    .fetch_valid     (fetch_valid),
    .fetch_instr     (fetch_instr),
    .fetch_pc        (fetch_pc),
    .fetch_ready     (fetch_ready),
    .issue_valid     (issue_valid),
    .issue_decoded   (issue_decoded),
    .issue_pc        (issue_pc),
    .issue_instr     (issue_instr),
    .issue_ex_ri     (issue_ex_ri),
    .issue_delayslot (issue_delayslot),
    .issue_num       (issue_num),
    .count           (count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      assert (issue_num <= ((count < 4'd2) ? count[1:0] : 2'd2))
        else $error("illegal issue_num %0d with count %0d", issue_num, count);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic decoded_instr_t dl(input int i);
    return decoded_instr_t'(issue_decoded[i]);
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    fetch_valid = '0;
    issue_num   = '0;
    flush       = 1'b0;
  endtask

  task automatic push(input logic [1:0] fv, input logic [31:0] i0, input logic [31:0] i1,
                      input logic [1:0] num);
    fetch_valid    = fv;
    fetch_instr[0] = i0;
    fetch_instr[1] = i1;
    fetch_pc[0]    = pc_ctr;
    fetch_pc[1]    = pc_ctr + 32'd4;
    pc_ctr         = pc_ctr + 32'd8;
    issue_num      = num;
    flush          = 1'b0;
    cyc();
    idle();
  endtask

  task automatic pop(input logic [1:0] n);
    issue_num = n;
    cyc();
    idle();
  endtask

  typedef struct {
    logic [1:0]  fv;
    logic [31:0] p0;
    logic [31:0] p1;
    logic [1:0]  num;
    logic        fl;
    logic [3:0]  e_count;
    logic        e_ready;
    logic [1:0]  e_valid;
    logic [31:0] e_pc0;
  } vec_t;

  vec_t vt [10];

  initial begin
    vt[0] = '{2'b11, B+32'h00, B+32'h04, 2'd0, 1'b0, 4'd2, 1'b1, 2'b11, B};
    vt[1] = '{2'b11, B+32'h08, B+32'h0C, 2'd0, 1'b0, 4'd4, 1'b1, 2'b11, B};
    vt[2] = '{2'b11, B+32'h10, B+32'h14, 2'd0, 1'b0, 4'd6, 1'b1, 2'b11, B};
    vt[3] = '{2'b11, B+32'h18, B+32'h1C, 2'd0, 1'b0, 4'd8, 1'b0, 2'b11, B};
    vt[4] = '{2'b11, B+32'h20, B+32'h24, 2'd0, 1'b0, 4'd8, 1'b0, 2'b11, B};
    vt[5] = '{2'b11, B+32'h20, B+32'h24, 2'd2, 1'b0, 4'd6, 1'b1, 2'b11, B+32'h08};
    vt[6] = '{2'b01, B+32'h20, B+32'h24, 2'd0, 1'b0, 4'd7, 1'b0, 2'b11, B+32'h08};
    vt[7] = '{2'b11, B+32'h24, B+32'h28, 2'd1, 1'b0, 4'd6, 1'b1, 2'b11, B+32'h0C};
    vt[8] = '{2'b11, B+32'h24, B+32'h28, 2'd2, 1'b0, 4'd6, 1'b1, 2'b11, B+32'h14};
    vt[9] = '{2'b11, B+32'h2C, B+32'h30, 2'd2, 1'b1, 4'd0, 1'b1, 2'b00, B};

    rst = 1'b1;
    fetch_instr = '0;
    fetch_pc    = '0;
    idle();
    repeat (3) cyc();
    rst = 1'b0;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_ready", 32'(fetch_ready), 32'd1);
    chk("rst_valid", 32'(issue_valid), 32'd0);

    // occupancy / flow-control table
    for (int k = 0; k < 10; k++) begin
      fetch_valid    = vt[k].fv;
      fetch_instr[0] = 32'h24020005;
      fetch_instr[1] = 32'h00000000;
      fetch_pc[0]    = vt[k].p0;
      fetch_pc[1]    = vt[k].p1;
      issue_num      = vt[k].num;
      flush          = vt[k].fl;
      cyc();
      chk($sformatf("v%0d_count", k), 32'(count), 32'(vt[k].e_count));
      chk($sformatf("v%0d_ready", k), 32'(fetch_ready), 32'(vt[k].e_ready));
      chk($sformatf("v%0d_valid", k), 32'(issue_valid), 32'(vt[k].e_valid));
      if (vt[k].e_valid[0]) chk($sformatf("v%0d_pc0", k), issue_pc[0], vt[k].e_pc0);
    end
    idle();
    cyc();

    // decode fields and one-cycle latency
    fetch_valid    = 2'b11;
    fetch_instr[0] = 32'h24020005;
    fetch_instr[1] = 32'h00000000;
    fetch_pc[0]    = 32'h100;
    fetch_pc[1]    = 32'h104;
    chk("lat_valid_same_cycle", 32'(issue_valid), 32'd0);
    cyc();
    idle();
    chk("dec_count", 32'(count), 32'd2);
    chk("dec_valid", 32'(issue_valid), 32'b11);
    chk("dec0_op", 32'(dl(0).op), 32'(OP_ADDU));
    chk("dec0_rd", 32'(dl(0).rd), 32'd2);
    chk("dec0_use_imm", 32'(dl(0).use_imm), 32'd1);
    chk("dec0_fu", 32'(dl(0).fu), 32'(FU_ALU));
    chk("dec0_imm", dl(0).imm, 32'd5);
    chk("dec1_op", 32'(dl(1).op), 32'(OP_SLL));
    chk("dec_pc1", issue_pc[1], 32'h104);
    chk("dec_instr0", issue_instr[0], 32'h24020005);
    chk("dec_ex_ri", 32'(issue_ex_ri), 32'd0);
    pop(2'd2);
    chk("dec_pop_count", 32'(count), 32'd0);

    // branch in last lane marks next group's lane 0
    push(2'b11, 32'h00000000, 32'h10000003, 2'd0);
    push(2'b11, 32'h00000000, 32'h24020005, 2'd0);
    chk("bq_count", 32'(count), 32'd4);
    chk("bq_ds0", 32'(issue_delayslot[0]), 32'd0);
    chk("bq_ds1", 32'(issue_delayslot[1]), 32'd0);
    chk("bq_cf1", 32'(dl(1).cf), 32'(ControlFlow_Branch));
    chk("bq_iscf1", 32'(dl(1).is_controlflow), 32'd1);
    pop(2'd2);
    chk("next_ds0", 32'(issue_delayslot[0]), 32'd1);
    chk("next_ds1", 32'(issue_delayslot[1]), 32'd0);
    pop(2'd2);
    push(2'b11, 32'h10000003, 32'h00000000, 2'd0);
    chk("inner_ds0", 32'(issue_delayslot[0]), 32'd0);
    chk("inner_ds1", 32'(issue_delayslot[1]), 32'd1);
    pop(2'd2);

    // reserved instruction
    push(2'b11, 32'hFC000000, 32'h24020005, 2'd0);
    chk("ri_ex0", 32'(issue_ex_ri[0]), 32'd1);
    chk("ri_op0", 32'(dl(0).op), 32'(OP_INVALID));
    chk("ri_fu0", 32'(dl(0).fu), 32'(FU_INVALID));
    chk("ri_ex1", 32'(issue_ex_ri[1]), 32'd0);
    chk("ri_op1", 32'(dl(1).op), 32'(OP_ADDU));
    chk("ri_ds1", 32'(issue_delayslot[1]), 32'd0);
    pop(2'd2);

    // flush with push and pop pending, last_cf set
    push(2'b11, 32'h00000000, 32'h00000000, 2'd0);
    push(2'b11, 32'h00000000, 32'h00000000, 2'd0);
    push(2'b01, 32'h10000003, 32'h00000000, 2'd0);
    chk("fl_pre_count", 32'(count), 32'd5);
    fetch_valid = 2'b11;
    issue_num   = 2'd2;
    flush       = 1'b1;
    cyc();
    idle();
    chk("fl_count", 32'(count), 32'd0);
    chk("fl_valid", 32'(issue_valid), 32'd0);
    chk("fl_ready", 32'(fetch_ready), 32'd1);
    push(2'b11, 32'h00000000, 32'h00000000, 2'd0);
    chk("fl_ds0", 32'(issue_delayslot[0]), 32'd0);
    pop(2'd2);

    // reset mid-stream discards entries and pending delay slot
    push(2'b11, 32'h00000000, 32'h00000000, 2'd0);
    push(2'b11, 32'h00000000, 32'h10000003, 2'd0);
    rst = 1'b1;
    fetch_valid = 2'b11;
    cyc();
    rst = 1'b0;
    idle();
    chk("mrst_count", 32'(count), 32'd0);
    chk("mrst_valid", 32'(issue_valid), 32'd0);
    push(2'b11, 32'h00000000, 32'h00000000, 2'd0);
    chk("mrst_ds0", 32'(issue_delayslot[0]), 32'd0);
    pop(2'd2);

    // streaming across the pointer wrap
    begin
      logic [31:0] np;
      logic [31:0] ep;
      np = B;
      ep = B;
      fetch_instr[0] = 32'h00000000;
      fetch_instr[1] = 32'h00000000;
      fetch_valid    = 2'b11;
      fetch_pc[0]    = np;
      fetch_pc[1]    = np + 32'd4;
      np             = np + 32'd8;
      issue_num      = 2'd0;
      cyc();
      for (int c = 0; c < 20; c++) begin
        chk($sformatf("st%0d_valid", c), 32'(issue_valid), 32'b11);
        chk($sformatf("st%0d_pc0", c), issue_pc[0], ep);
        chk($sformatf("st%0d_pc1", c), issue_pc[1], ep + 32'd4);
        fetch_valid = 2'b11;
        fetch_pc[0] = np;
        fetch_pc[1] = np + 32'd4;
        np          = np + 32'd8;
        issue_num   = 2'd2;
        cyc();
        ep = ep + 32'd8;
      end
      idle();
      chk("st_end_count", 32'(count), 32'd2);
      chk("st_end_pc0", issue_pc[0], ep);
      chk("st_end_pc1", issue_pc[1], ep + 32'd4);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
